// File: rtl/uart_pkg.sv
// Shared definitions for the UART command transmitter.
// Optional 8E1 framing is selected with UART_TX_PARITY_EN.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic LINE_IDLE = 1'b1;

    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte write handshake between the upstream producer and uart_cmd_tx.
interface uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with a registered occupancy counter.
module uart_tx_fifo #(
    parameter  int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= din;
        end
    end

    // Depth is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + 1'b1;
            end else if (!push_ok && pop_ok) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// UART transmitter with byte FIFO; 8N1 by default, 8E1 when
// UART_TX_PARITY_EN is defined.
module uart_cmd_tx
    import uart_pkg::*;
#(
    parameter  int CLK_FREQ   = 50_000_000,
    parameter  int BAUD_RATE  = 115_200,
    parameter  int FIFO_DEPTH = 16,
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_if.slave      tx,
    output logic          uart_txd,
    output logic          tx_busy,
    output logic [LW-1:0] fifo_level
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam int BW = $clog2(BAUD_DIV);

    logic [2:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_byte;
    logic          bit_end;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    dout;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx.tx_valid & tx.tx_ready),
        .pop   (pop),
        .din   (tx.tx_data),
        .dout  (dout),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign tx.tx_ready = ~full;
    assign tx_busy     = (state != ST_IDLE) | (fifo_level != '0);
    assign bit_end     = (baud_cnt == BW'(BAUD_DIV - 1));

    // Pops happen from IDLE, or back-to-back at the end of STOP.
    assign pop = ~empty &
                 ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_byte <= '0;
            uart_txd   <= LINE_IDLE;
        end else begin
            if (state != ST_IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            end
            unique case (1'b1)
                (state == ST_IDLE): begin
                    if (!empty) begin
                        shift_byte <= dout;
                        state      <= ST_START;
                        uart_txd   <= 1'b0;
                        baud_cnt   <= '0;
                    end
                end
                (state == ST_START): begin
                    if (bit_end) begin
                        state    <= ST_DATA;
                        bit_cnt  <= '0;
                        uart_txd <= shift_byte[0];
                    end
                end
                (state == ST_DATA): begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                            state    <= ST_PARITY;
                            uart_txd <= ^shift_byte;
`else
                            state    <= ST_STOP;
                            uart_txd <= LINE_IDLE;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            uart_txd <= shift_byte[bit_cnt + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                (state == ST_PARITY): begin
                    if (bit_end) begin
                        state    <= ST_STOP;
                        uart_txd <= LINE_IDLE;
                    end
                end
`endif
                (state == ST_STOP): begin
                    if (bit_end) begin
                        if (!empty) begin
                            shift_byte <= dout;
                            state      <= ST_START;
                            uart_txd   <= 1'b0;
                        end else begin
                            state      <= ST_IDLE;
                            uart_txd   <= LINE_IDLE;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    uart_txd <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Scoreboard bench for uart_cmd_tx: a line receiver model checks every frame.
module tb_uart_cmd_tx;

    localparam int B = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       txd;
    logic       busy;
    logic [4:0] level;
    logic       txd_d;
    logic       busy_d;
    logic [4:0] level_d;

    int         cyc = 0;
    int         vec = 0;
    int         errs = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_if bus ();
    uart_tx_if bus_d ();

    uart_cmd_tx #(
        .CLK_FREQ   (1_000_000),
        .BAUD_RATE  (100_000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx         (bus),
        .uart_txd   (txd),
        .tx_busy    (busy),
        .fifo_level (level)
    );

    uart_cmd_tx dut_d (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx         (bus_d),
        .uart_txd   (txd_d),
        .tx_busy    (busy_d),
        .fifo_level (level_d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, int act, int req);
        vec++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, req, cyc);
        end
    endfunction

    // Expected line levels of one frame, index 0 = start bit.
    function automatic logic [10:0] frame_bits(logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = 1'($countones(b) % 2);
`endif
        return f;
    endfunction

    // Receiver: every bit must hold for exactly B clocks.
    initial begin
        logic [10:0] bits;
        logic        first;
        logic [7:0]  e;
        bit          stable;
        bit          abort;
        int          st;
        forever begin
            @(negedge clk);
            if (rst_n && txd == 1'b0) begin
                bits = '1;
                stable = 1'b1;
                abort = 1'b0;
                first = 1'b0;
                st = cyc;
                for (int i = 0; i < NB && !abort; i++) begin
                    for (int j = 0; j < B; j++) begin
                        if (!(i == 0 && j == 0)) @(negedge clk);
                        if (!rst_n) begin
                            abort = 1'b1;
                            break;
                        end
                        if (j == 0) first = txd;
                        else if (txd != first) stable = 1'b0;
                        if (j == B / 2) bits[i] = txd;
                    end
                end
                if (!abort) begin
                    starts.push_back(st);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", int'(bits), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", int'(bits), int'(frame_bits(e)));
                        check("bit_hold", int'(stable), 1);
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, output int acc, output int waited);
        int n;
        n = 0;
        @(negedge clk);
        bus.tx_data = b;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (n >= 5000) begin
            check("push_timeout", n, 0);
            bus.tx_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            exp_q.push_back(b);
            #1;
            acc = cyc;
            bus.tx_valid = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, output int t);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) check("idle_timeout", n, 0);
        t = cyc;
    endtask

    initial begin
        int k;
        int k0;
        int t;
        int w;
        int s2;
        int n;
        int t0;
        int t1;
        int nst;
        bit held;
        bit quiet;
        logic [7:0] rx;

        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        bus_d.tx_data = '0;
        bus_d.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", int'(txd), 1);
        check("rst_ready", int'(bus.tx_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_level", int'(level), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single byte latency and frame length
        push(8'h55, k, w);
        @(negedge clk);
        check("t1_txd_at_accept", int'(txd), 1);
        check("t1_level_queued", int'(level), 1);
        @(negedge clk);
        check("t1_txd_start", int'(txd), 0);
        check("t1_level_popped", int'(level), 0);
        check("t1_busy", int'(busy), 1);
        wait_idle(3 * FL, t);
        check("t1_busy_fall", t - (k + 1), FL);

        // 17-byte burst fills the FIFO
        nst = starts.size();
        for (int i = 0; i < 17; i++) begin
            push(8'(i), k, w);
            if (i == 0) k0 = k;
        end
        @(negedge clk);
        check("t2_level_full", int'(level), 16);
        check("t2_ready_low", int'(bus.tx_ready), 0);
        wait_idle(20 * FL, t);
        check("t2_burst_len", t - (k0 + 1), 17 * FL);
        @(negedge clk);
        if (starts.size() >= nst + 17)
            check("t2_contiguous", starts[nst + 16] - starts[nst], 16 * FL);
        else
            check("t2_frame_count", starts.size() - nst, 17);

`ifdef UART_TX_PARITY_EN
        push(8'h07, k, w);
        wait_cyc(k + 1 + 95);
        check("t3_parity_07", int'(txd), 1);
        wait_cyc(k + 1 + 105);
        check("t3_stop_07", int'(txd), 1);
        wait_idle(3 * FL, t);
        check("t3_frame_len", t - (k + 1), 110);
        push(8'h03, k, w);
        wait_cyc(k + 1 + 95);
        check("t3_parity_03", int'(txd), 0);
        wait_idle(3 * FL, t);
`endif

        // reset during data bit 4 of the second frame
        for (int i = 0; i < 5; i++) begin
            push(8'($urandom), k, w);
            if (i == 0) k0 = k;
        end
        s2 = k0 + 1 + FL;
        wait_cyc(s2 + 5 * B + 3);
        check("t4_queued", int'(level), 3);
        rst_n = 1'b0;
        #1;
        check("t4_txd_high", int'(txd), 1);
        check("t4_level_flush", int'(level), 0);
        check("t4_busy_low", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_ready", int'(bus.tx_ready), 1);
        quiet = 1'b1;
        repeat (3 * FL) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("t4_no_residual", int'(quiet), 1);

        // push coinciding with a pop, then a held push while full
        for (int i = 0; i < 6; i++) begin
            push(8'($urandom), k, w);
            if (i == 0) k0 = k;
        end
        wait_cyc(k0 + FL);
        check("t5_level_before", int'(level), 5);
        rx = 8'($urandom);
        bus.tx_data = rx;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(rx);
        #1;
        bus.tx_valid = 1'b0;
        @(negedge clk);
        check("t5_level_kept", int'(level), 5);
        check("t5_next_start", int'(txd), 0);
        held = 1'b0;
        for (int i = 0; i < 13; i++) begin
            push(8'($urandom), k, w);
            if (w > 0) held = 1'b1;
        end
        check("t5_held_push", int'(held), 1);
        wait_idle(25 * FL, t);

        // random bytes with random gaps
        for (int i = 0; i < 24; i++) begin
            push(8'($urandom), k, w);
            repeat ($urandom_range(0, 2 * FL)) @(negedge clk);
        end
        wait_idle(30 * FL, t);

        // default parameters: 434-clock bit period
        @(negedge clk);
        bus_d.tx_data = 8'hA3;
        bus_d.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_d.tx_valid = 1'b0;
        n = 0;
        while (txd_d && n < 100) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        while (!txd_d && n < 2000) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        check("t6_bit_period", t1 - t0, 434);
        rx = '0;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(t0 + 434 * (i + 1) + 217);
            rx[i] = txd_d;
        end
        check("t6_byte", int'(rx), 8'hA3);
        n = 0;
        while (busy_d && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("t6_stop_high", int'(txd_d), 1);

        n = 0;
        while (exp_q.size() != 0 && n < 5 * FL) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
